// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: drives the stall/zero controls of
// the pipeline registers and the PC enable, and tracks memory timeouts and stall cycles.
module pipe_hazard_ctrl #(
    parameter int unsigned MUL_CYCLES  = 4,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        reset,
    input  logic [4:0]  id_rs_i,
    input  logic [4:0]  id_rt_i,
    input  logic        id_uses_rt_i,
    input  logic [4:0]  ex_rt_i,
    input  logic        ex_mem_read_i,
    input  logic        ex_mul_start_i,
    input  logic        mem_req_i,
    input  logic        mem_ready_i,
    input  logic        branch_taken_i,
    output logic        pc_write_o,
    output logic        if_id_stall_o,
    output logic        id_ex_stall_o,
    output logic        ex_mem_stall_o,
    output logic        if_id_zero_o,
    output logic        id_ex_zero_o,
    output logic        ex_mem_zero_o,
    output logic        mem_wb_zero_o,
    output logic        mem_timeout_o,
    output logic [31:0] stall_cycles_o
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMulBusy = 2'd1,
        StMemWait = 2'd2
    } state_e;

    localparam logic [3:0] MulLoad   = 4'(MUL_CYCLES - 1);
    localparam logic [7:0] WaitLimit = 8'(MEM_TIMEOUT);

    state_e      r_state;
    state_e      w_state_d;
    state_e      w_eff_state;
    logic        r_ret_mul;
    logic        w_ret_mul_d;
    logic [3:0]  r_mul_cnt;
    logic [3:0]  w_mul_cnt_d;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_cnt_d;
    logic        r_timeout;
    logic        w_timeout_d;
    logic [31:0] r_stall_cycles;
    logic [31:0] w_stall_cycles_d;
    logic        w_mem_wait;
    logic        w_load_use;
    logic        w_mul_hold;

    assign w_mem_wait = mem_req_i & ~mem_ready_i;
    assign w_load_use = ex_mem_read_i & (ex_rt_i != 5'd0) &
                        ((ex_rt_i == id_rs_i) | (id_uses_rt_i & (ex_rt_i == id_rt_i)));

    // A MEM wait only freezes the pipeline, so decisions are made against the state it interrupted.
    assign w_eff_state = (r_state == StMemWait) ? (r_ret_mul ? StMulBusy : StRun) : r_state;

    always_comb begin
        w_state_d    = w_eff_state;
        w_ret_mul_d  = r_ret_mul;
        w_mul_cnt_d  = r_mul_cnt;
        w_wait_cnt_d = 8'd0;
        w_timeout_d  = r_timeout;
        w_mul_hold   = 1'b0;
        if (w_mem_wait) begin
            w_state_d    = StMemWait;
            w_ret_mul_d  = (w_eff_state == StMulBusy);
            w_wait_cnt_d = (r_wait_cnt != 8'hFF) ? r_wait_cnt + 8'd1 : r_wait_cnt;
            if (w_wait_cnt_d >= WaitLimit) begin
                w_timeout_d = 1'b1;
            end
        end else if (branch_taken_i) begin
            w_state_d   = StRun;
            w_mul_cnt_d = 4'd0;
        end else begin
            case (w_eff_state)
                StRun: begin
                    if (ex_mul_start_i) begin
                        w_mul_cnt_d = MulLoad;
                        w_state_d   = StMulBusy;
                        w_mul_hold  = 1'b1;
                    end
                end
                StMulBusy: begin
                    if (r_mul_cnt != 4'd0) begin
                        w_mul_cnt_d = r_mul_cnt - 4'd1;
                    end
                    // The final EX cycle of the op advances normally so EX_MEM captures its result.
                    w_mul_hold = (w_mul_cnt_d != 4'd0);
                    w_state_d  = w_mul_hold ? StMulBusy : StRun;
                end
                default: begin
                    w_state_d = StRun;
                end
            endcase
        end
    end

    always_comb begin
        pc_write_o     = 1'b1;
        if_id_stall_o  = 1'b0;
        id_ex_stall_o  = 1'b0;
        ex_mem_stall_o = 1'b0;
        if_id_zero_o   = 1'b0;
        id_ex_zero_o   = 1'b0;
        ex_mem_zero_o  = 1'b0;
        mem_wb_zero_o  = 1'b0;
        if (!reset) begin
            pc_write_o    = 1'b0;
            if_id_zero_o  = 1'b1;
            id_ex_zero_o  = 1'b1;
            ex_mem_zero_o = 1'b1;
            mem_wb_zero_o = 1'b1;
        end else if (w_mem_wait) begin
            pc_write_o     = 1'b0;
            if_id_stall_o  = 1'b1;
            id_ex_stall_o  = 1'b1;
            ex_mem_stall_o = 1'b1;
            mem_wb_zero_o  = 1'b1;
        end else if (branch_taken_i) begin
            if_id_zero_o  = 1'b1;
            id_ex_zero_o  = 1'b1;
            ex_mem_zero_o = 1'b1;
        end else if (w_mul_hold) begin
            pc_write_o    = 1'b0;
            if_id_stall_o = 1'b1;
            id_ex_stall_o = 1'b1;
            ex_mem_zero_o = 1'b1;
        end else if (w_load_use) begin
            pc_write_o    = 1'b0;
            if_id_stall_o = 1'b1;
            id_ex_zero_o  = 1'b1;
        end
    end

    assign w_stall_cycles_d = (!pc_write_o && (r_stall_cycles != 32'hFFFF_FFFF)) ?
                              r_stall_cycles + 32'd1 : r_stall_cycles;

    always_ff @(posedge clk_i) begin
        if (!reset) begin
            r_state        <= StRun;
            r_ret_mul      <= 1'b0;
            r_mul_cnt      <= 4'd0;
            r_wait_cnt     <= 8'd0;
            r_timeout      <= 1'b0;
            r_stall_cycles <= 32'd0;
        end else begin
            r_state        <= w_state_d;
            r_ret_mul      <= w_ret_mul_d;
            r_mul_cnt      <= w_mul_cnt_d;
            r_wait_cnt     <= w_wait_cnt_d;
            r_timeout      <= w_timeout_d;
            r_stall_cycles <= w_stall_cycles_d;
        end
    end

    assign mem_timeout_o  = r_timeout;
    assign stall_cycles_o = r_stall_cycles;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: decode table, hand-written multi-cycle sequences and random
// stimulus, all checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned TbMul = 4;
    localparam int unsigned TbTo  = 3;

    localparam logic [7:0] CNorm = 8'b1000_0000;
    localparam logic [7:0] CLu   = 8'b0100_0100;
    localparam logic [7:0] CMul  = 8'b0110_0010;
    localparam logic [7:0] CMemW = 8'b0111_0001;
    localparam logic [7:0] CBr   = 8'b1000_1110;
    localparam logic [7:0] CRst  = 8'b0000_1111;

    typedef struct packed {
        logic       rstn;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic [4:0] ex_rt;
        logic       mem_read;
        logic       mul_start;
        logic       mem_req;
        logic       mem_ready;
        logic       branch;
    } stim_t;

    typedef struct {
        string      name;
        stim_t      s;
        logic [7:0] ctrl;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_mem_read, ex_mul_start, mem_req, mem_ready, branch_taken;
    logic        pc_write, if_id_stall, id_ex_stall, ex_mem_stall;
    logic        if_id_zero, id_ex_zero, ex_mem_zero, mem_wb_zero, mem_timeout;
    logic [31:0] stall_cycles;
    logic [7:0]  w_ctrl;

    always #5 clk_i = ~clk_i;

    pipe_hazard_ctrl #(
        .MUL_CYCLES (TbMul),
        .MEM_TIMEOUT(TbTo)
    ) u_dut (
        .clk_i         (clk_i),
        .reset         (reset),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_uses_rt_i  (id_uses_rt),
        .ex_rt_i       (ex_rt),
        .ex_mem_read_i (ex_mem_read),
        .ex_mul_start_i(ex_mul_start),
        .mem_req_i     (mem_req),
        .mem_ready_i   (mem_ready),
        .branch_taken_i(branch_taken),
        .pc_write_o    (pc_write),
        .if_id_stall_o (if_id_stall),
        .id_ex_stall_o (id_ex_stall),
        .ex_mem_stall_o(ex_mem_stall),
        .if_id_zero_o  (if_id_zero),
        .id_ex_zero_o  (id_ex_zero),
        .ex_mem_zero_o (ex_mem_zero),
        .mem_wb_zero_o (mem_wb_zero),
        .mem_timeout_o (mem_timeout),
        .stall_cycles_o(stall_cycles)
    );

    assign w_ctrl = {pc_write, if_id_stall, id_ex_stall, ex_mem_stall,
                     if_id_zero, id_ex_zero, ex_mem_zero, mem_wb_zero};

    int n_vec = 0;
    int n_bad = 0;

    // Model: m_rem counts EX cycles the multi-cycle op still owes, m_wait counts consecutive waits.
    int          m_rem = 0, n_rem = 0;
    int          m_wait = 0, n_wait = 0;
    logic        m_to = 1'b0, n_to = 1'b0;
    logic [31:0] m_cnt = '0, n_cnt = '0;
    logic [7:0]  e_ctrl;

    always @(posedge clk_i) begin
        m_rem  <= n_rem;
        m_wait <= n_wait;
        m_to   <= n_to;
        m_cnt  <= n_cnt;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task model(input stim_t s);
        logic lu;
        n_rem  = m_rem;
        n_wait = m_wait;
        n_to   = m_to;
        n_cnt  = m_cnt;
        lu = s.mem_read && (s.ex_rt != 0) &&
             ((s.ex_rt == s.rs) || (s.uses_rt && (s.ex_rt == s.rt)));
        if (!s.rstn) begin
            e_ctrl = CRst;
            n_rem  = 0;
            n_wait = 0;
            n_to   = 1'b0;
            n_cnt  = '0;
        end else begin
            if (s.mem_req && !s.mem_ready) begin
                e_ctrl = CMemW;
                n_wait = m_wait + 1;
                if (n_wait >= TbTo) n_to = 1'b1;
            end else begin
                n_wait = 0;
                if (s.branch) begin
                    e_ctrl = CBr;
                    n_rem  = 0;
                end else begin
                    if (n_rem == 0 && s.mul_start) n_rem = TbMul;
                    if (n_rem > 0) n_rem = n_rem - 1;
                    if (n_rem > 0) e_ctrl = CMul;
                    else if (lu) e_ctrl = CLu;
                    else e_ctrl = CNorm;
                end
            end
            if (!e_ctrl[7] && n_cnt != 32'hFFFF_FFFF) n_cnt = n_cnt + 1;
        end
    endtask

    task automatic step(input stim_t s, input string tag);
        @(negedge clk_i);
        reset        = s.rstn;
        id_rs        = s.rs;
        id_rt        = s.rt;
        id_uses_rt   = s.uses_rt;
        ex_rt        = s.ex_rt;
        ex_mem_read  = s.mem_read;
        ex_mul_start = s.mul_start;
        mem_req      = s.mem_req;
        mem_ready    = s.mem_ready;
        branch_taken = s.branch;
        #1;
        model(s);
        check({tag, " ctrl"}, {24'b0, w_ctrl}, {24'b0, e_ctrl});
        check({tag, " timeout"}, {31'b0, mem_timeout}, {31'b0, m_to});
        check({tag, " stall_cycles"}, stall_cycles, m_cnt);
    endtask

    function automatic stim_t st(input logic rd, input logic [4:0] exrt, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic uses, input logic mul,
                                 input logic req, input logic rdy, input logic br);
        stim_t s;
        s.rstn      = 1'b1;
        s.mem_read  = rd;
        s.ex_rt     = exrt;
        s.rs        = rs;
        s.rt        = rt;
        s.uses_rt   = uses;
        s.mul_start = mul;
        s.mem_req   = req;
        s.mem_ready = rdy;
        s.branch    = br;
        return s;
    endfunction

    stim_t idle, rst, wt, wtbr, rdy, rdybr, brs, mul;
    vec_t  tbl[$];

    initial begin
        idle  = st(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst   = idle;
        rst.rstn = 1'b0;
        wt    = st(0, 0, 0, 0, 0, 0, 1, 0, 0);
        wtbr  = st(0, 0, 0, 0, 0, 0, 1, 0, 1);
        rdy   = st(0, 0, 0, 0, 0, 0, 1, 1, 0);
        rdybr = st(0, 0, 0, 0, 0, 0, 1, 1, 1);
        brs   = st(0, 0, 0, 0, 0, 0, 0, 0, 1);
        mul   = st(0, 0, 0, 0, 0, 1, 0, 0, 0);

        tbl.push_back('{"idle",          idle,                            CNorm});
        tbl.push_back('{"lu_rs",         st(1, 5, 5, 0, 0, 0, 0, 0, 0),   CLu});
        tbl.push_back('{"lu_rt0",        st(1, 0, 0, 0, 1, 0, 0, 0, 0),   CNorm});
        tbl.push_back('{"lu_rt",         st(1, 7, 1, 7, 1, 0, 0, 0, 0),   CLu});
        tbl.push_back('{"lu_rt_unused",  st(1, 7, 1, 7, 0, 0, 0, 0, 0),   CNorm});
        tbl.push_back('{"no_load",       st(0, 5, 5, 5, 1, 0, 0, 0, 0),   CNorm});
        tbl.push_back('{"branch",        brs,                             CBr});
        tbl.push_back('{"branch_lu",     st(1, 5, 5, 0, 0, 0, 0, 0, 1),   CBr});
        tbl.push_back('{"memwait",       wt,                              CMemW});
        tbl.push_back('{"memwait_br",    st(1, 5, 5, 0, 0, 1, 1, 0, 1),   CMemW});
        tbl.push_back('{"mem_ready",     rdy,                             CNorm});
        tbl.push_back('{"mul_start",     mul,                             CMul});
        tbl.push_back('{"mul_lu",        st(1, 5, 5, 0, 0, 1, 0, 0, 0),   CMul});
        tbl.push_back('{"branch_mul",    st(0, 0, 0, 0, 0, 1, 0, 0, 1),   CBr});

        // Bring the DUT out of X before any comparison.
        reset = 1'b0;
        {id_rs, id_rt, ex_rt} = '0;
        {id_uses_rt, ex_mem_read, ex_mul_start, mem_req, mem_ready, branch_taken} = '0;
        repeat (2) @(posedge clk_i);

        step(rst, "reset");
        check("reset forced ctrl", {24'b0, w_ctrl}, {24'b0, CRst});
        check("reset stall_cycles", stall_cycles, 32'd0);
        check("reset timeout", {31'b0, mem_timeout}, 32'd0);

        foreach (tbl[i]) begin
            step(rst, "tbl_rst");
            step(tbl[i].s, tbl[i].name);
            check({"tbl ", tbl[i].name}, {24'b0, w_ctrl}, {24'b0, tbl[i].ctrl});
        end

        // Load-use holds for exactly one cycle.
        step(rst, "lu_seq");
        step(st(1, 5, 5, 0, 0, 0, 0, 0, 0), "lu_seq");
        step(idle, "lu_seq");
        check("lu released", {24'b0, w_ctrl}, {24'b0, CNorm});
        check("lu one stall", stall_cycles, 32'd1);

        // Branch flush does not count as a stall.
        step(rst, "br_seq");
        step(brs, "br_seq");
        step(idle, "br_seq");
        check("branch no stall count", stall_cycles, 32'd0);

        // Multi-cycle op: MUL_CYCLES-1 held cycles, then normal advance.
        step(rst, "mul_seq");
        step(mul, "mul_seq");
        check("mul c0", {24'b0, w_ctrl}, {24'b0, CMul});
        step(idle, "mul_seq");
        check("mul c1", {24'b0, w_ctrl}, {24'b0, CMul});
        step(idle, "mul_seq");
        check("mul c2", {24'b0, w_ctrl}, {24'b0, CMul});
        step(idle, "mul_seq");
        check("mul done", {24'b0, w_ctrl}, {24'b0, CNorm});
        check("mul stall count", stall_cycles, 32'd3);

        // Memory wait with a held branch: flush only in the ready cycle.
        step(rst, "mw_seq");
        for (int i = 0; i < 5; i++) begin
            step(wtbr, "mw_seq");
            check("mw held", {24'b0, w_ctrl}, {24'b0, CMemW});
        end
        step(rdybr, "mw_seq");
        check("mw release flush", {24'b0, w_ctrl}, {24'b0, CBr});
        step(idle, "mw_seq");
        check("mw stall count", stall_cycles, 32'd5);
        check("mw timeout set", {31'b0, mem_timeout}, 32'd1);

        // Timeout needs MEM_TIMEOUT consecutive waits and is sticky until reset.
        step(rst, "to_seq");
        step(wt, "to_seq");
        step(wt, "to_seq");
        step(rdy, "to_seq");
        step(wt, "to_seq");
        step(wt, "to_seq");
        check("to not consecutive", {31'b0, mem_timeout}, 32'd0);
        step(wt, "to_seq");
        step(rdy, "to_seq");
        check("to set", {31'b0, mem_timeout}, 32'd1);
        step(idle, "to_seq");
        check("to sticky", {31'b0, mem_timeout}, 32'd1);
        step(rst, "to_seq");
        step(idle, "to_seq");
        check("to cleared", {31'b0, mem_timeout}, 32'd0);

        // Branch in the second cycle of a multi-cycle op cancels it.
        step(rst, "brmul_seq");
        step(mul, "brmul_seq");
        step(brs, "brmul_seq");
        check("brmul flush", {24'b0, w_ctrl}, {24'b0, CBr});
        step(idle, "brmul_seq");
        check("brmul no stall", {24'b0, w_ctrl}, {24'b0, CNorm});

        // Memory wait freezes a multi-cycle op; it resumes where it stopped.
        step(rst, "mulwait_seq");
        step(mul, "mulwait_seq");
        step(wt, "mulwait_seq");
        step(wt, "mulwait_seq");
        step(rdy, "mulwait_seq");
        check("mulwait resume", {24'b0, w_ctrl}, {24'b0, CMul});
        step(idle, "mulwait_seq");
        check("mulwait last hold", {24'b0, w_ctrl}, {24'b0, CMul});
        step(idle, "mulwait_seq");
        check("mulwait done", {24'b0, w_ctrl}, {24'b0, CNorm});

        // Reset during a memory wait aborts it.
        step(rst, "rstwait_seq");
        step(mul, "rstwait_seq");
        step(wt, "rstwait_seq");
        begin
            stim_t r;
            r = wt;
            r.rstn = 1'b0;
            step(r, "rstwait_seq");
            check("rstwait forced", {24'b0, w_ctrl}, {24'b0, CRst});
        end
        step(idle, "rstwait_seq");
        check("rstwait run", {24'b0, w_ctrl}, {24'b0, CNorm});
        check("rstwait count", stall_cycles, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            stim_t s;
            s.rstn      = ($urandom_range(99) != 0);
            s.rs        = 5'($urandom_range(3));
            s.rt        = 5'($urandom_range(3));
            s.ex_rt     = 5'($urandom_range(3));
            s.uses_rt   = 1'($urandom_range(1));
            s.mem_read  = ($urandom_range(2) == 0);
            s.mul_start = ($urandom_range(7) == 0);
            s.mem_req   = ($urandom_range(2) == 0);
            s.mem_ready = 1'($urandom_range(1));
            s.branch    = ($urandom_range(9) == 0);
            step(s, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline. It drives the stall/zero (flush) controls of the four pipeline registers IF_ID, ID_EX, EX_MEM and MEM_WB, plus the PC write enable. It resolves load-use interlocks, taken-branch flushes (branch resolved in MEM), multi-cycle EX operations and data-memory wait states. It also keeps a memory-timeout flag and a stall-cycle performance counter.

Parameters:
MUL_CYCLES, 4, total EX-stage occupancy of a multi-cycle op (legal range 2..15)
MEM_TIMEOUT, 255, max consecutive MEM wait cycles before error flag sets (1..255)

Ports:
clk_i  in  1  clock, all state updates on rising edge
reset  in  1  reset, synchronous, active-low
id_rs_i  in  5  rs of instruction in ID
id_rt_i  in  5  rt of instruction in ID
id_uses_rt_i  in  1  ID instruction reads rt
ex_rt_i  in  5  destination rt of instruction in EX
ex_mem_read_i  in  1  EX instruction is a load
ex_mul_start_i  in  1  EX instruction is a multi-cycle op (high on its first EX cycle)
mem_req_i  in  1  MEM instruction accesses data memory
mem_ready_i  in  1  data memory completes this cycle
branch_taken_i  in  1  MEM-stage branch resolved taken
pc_write_o  out  1  PC update enable
if_id_stall_o, id_ex_stall_o, ex_mem_stall_o  out  1 each  hold register
if_id_zero_o, id_ex_zero_o, ex_mem_zero_o, mem_wb_zero_o  out  1 each  load zero (bubble/flush)
mem_timeout_o  out  1  sticky error flag
stall_cycles_o  out  32  saturating count of cycles with pc_write_o=0

Behaviour:
- State register FSM: RUN, MUL_BUSY, MEM_WAIT. Also mul_cnt[3:0], wait_cnt[7:0], stall_cycles, timeout flag.
- Reset (reset==0 at posedge): state=RUN, mul_cnt=0, wait_cnt=0, stall_cycles=0, mem_timeout_o=0.
- While reset==0, outputs are forced: pc_write_o=0, all *_stall_o=0, all *_zero_o=1.
- Outputs are combinational from the current state and inputs, giving zero-cycle response. Zero has priority over stall inside the registers, so the controller never asserts both for one register.
- Conditions, highest priority first:
  1. mem_wait = mem_req_i & ~mem_ready_i. Drives pc_write=0, stall IF_ID/ID_EX/EX_MEM, mem_wb_zero=1. Next state is MEM_WAIT, wait_cnt++. branch_taken_i is ignored while mem_wait, because MEM is held and the branch re-presents. mul_cnt is frozen.
  2. branch_taken_i: pc_write=1 (target loads), if_id/id_ex/ex_mem zero=1, no stalls. Cancels any multi-cycle op: mul_cnt=0, state=RUN.
  3. Multi-cycle op. On entry, ex_mul_start_i in RUN loads mul_cnt=MUL_CYCLES-1 and sets state=MUL_BUSY. While mul_cnt!=0: pc_write=0, stall IF_ID and ID_EX, ex_mem_zero=1, decrement each cycle. When mul_cnt reaches 0, state=RUN and normal advance resumes, so the op writes EX_MEM exactly MUL_CYCLES cycles after entering EX. ex_mul_start_i is ignored in MUL_BUSY.
  4. Load-use: ex_mem_read_i & ex_rt_i!=0 & (ex_rt_i==id_rs_i | id_uses_rt_i & ex_rt_i==id_rt_i). Drives pc_write=0, if_id_stall=1, id_ex_zero=1, for exactly one cycle per occurrence.
  5. Otherwise: pc_write=1, all stall/zero=0.
- MEM_WAIT exits to its prior state (RUN or MUL_BUSY) in the cycle mem_ready_i is seen, and wait_cnt clears.
- When wait_cnt reaches MEM_TIMEOUT, mem_timeout_o=1. The flag is sticky until reset, and stall behaviour continues.
- stall_cycles_o increments on every non-reset cycle with pc_write_o=0 and saturates at 0xFFFFFFFF.
- Reset mid-operation aborts MUL_BUSY/MEM_WAIT immediately with no residual stall.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 for one cycle -> pc_write=0, if_id_stall=1, id_ex_zero=1 for 1 cycle; with ex_rt=0 -> no stall.
- Branch: branch_taken=1 for one cycle -> if_id/id_ex/ex_mem_zero=1, pc_write=1, mem_wb_zero=0; stall_cycles unchanged.
- Multi-cycle: MUL_CYCLES=4, ex_mul_start pulse -> 3 cycles of pc_write=0, id_ex_stall=1, ex_mem_zero=1, then normal; stall_cycles +3.
- Memory wait: mem_req=1, mem_ready low 5 cycles then high -> 5 cycles of all upstream stall plus mem_wb_zero, release on ready cycle; branch_taken held high meanwhile flushes only after release.
- Timeout: MEM_TIMEOUT=3, mem_ready held low 3 cycles -> mem_timeout_o=1 and stays 1 after ready; clears only on reset=0.
- Branch during multi-cycle op plus reset: branch_taken in 2nd MUL cycle -> flush, state RUN, no further stall; reset=0 during MEM_WAIT -> next cycle RUN, zeros=1, stall_cycles=0.
